// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment scan driver:
//   - active-low segment patterns {a,b,c,d,e,f,g,dp} for codes 0-9 and A-F,
//     with the dp bit held at 1 (off) so it can be ANDed in later
//   - the two-state scan FSM encoding
//   - a small max() helper for sizing counters from parameters
// No ports (package).
// -----------------------------------------------------------------------------
package seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_e;

   localparam logic [7:0] SEG_0     = 8'h03;
   localparam logic [7:0] SEG_1     = 8'h9F;
   localparam logic [7:0] SEG_2     = 8'h25;
   localparam logic [7:0] SEG_3     = 8'h0D;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h49;
   localparam logic [7:0] SEG_6     = 8'h41;
   localparam logic [7:0] SEG_7     = 8'h1F;
   localparam logic [7:0] SEG_8     = 8'h01;
   localparam logic [7:0] SEG_9     = 8'h09;
   localparam logic [7:0] SEG_A     = 8'h11;
   localparam logic [7:0] SEG_B     = 8'hC1;
   localparam logic [7:0] SEG_C     = 8'h63;
   localparam logic [7:0] SEG_D     = 8'h85;
   localparam logic [7:0] SEG_E     = 8'h61;
   localparam logic [7:0] SEG_F     = 8'h71;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic int seg_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg_scan_driver_decode.sv
// -----------------------------------------------------------------------------
// seg_decode
// Combinational 4-bit code to active-low segment lookup.
// Parameters:
//   HEX_MODE : 0 -> codes 10-15 are blank, 1 -> codes 10-15 show A,b,C,d,E,F
// Ports:
//   code_i [3:0] : digit code
//   seg_o  [7:0] : {a,b,c,d,e,f,g,dp}, active-low, dp bit always 1 (off)
// -----------------------------------------------------------------------------
module seg_decode
   import seg_pkg::*;
#(
   parameter int HEX_MODE = 0
) (
   input  logic [3:0] code_i,
   output logic [7:0] seg_o
);

   // NOTE: assigning a default before the case keeps this purely
   // combinational; any path that skipped seg_o would infer a latch.
   always_comb begin
      seg_o = SEG_BLANK;
      case (code_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = (HEX_MODE != 0) ? SEG_A : SEG_BLANK;
         4'hB: seg_o = (HEX_MODE != 0) ? SEG_B : SEG_BLANK;
         4'hC: seg_o = (HEX_MODE != 0) ? SEG_C : SEG_BLANK;
         4'hD: seg_o = (HEX_MODE != 0) ? SEG_D : SEG_BLANK;
         4'hE: seg_o = (HEX_MODE != 0) ? SEG_E : SEG_BLANK;
         4'hF: seg_o = (HEX_MODE != 0) ? SEG_F : SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Each digit gets BLANK_CYCLES of all-anodes-off (ghost suppression) followed
// by REFRESH_DIV cycles of drive. Display data is double-buffered: load fills
// a pending buffer, which is copied to the active buffer only when the scan
// index wraps, so a frame never mixes old and new data.
//
// Optional feature (macro SEG_SCAN_BLINK_EN): adds blink_mask input and
// BLINK_FRAMES parameter; masked digits go dark every other BLINK_FRAMES
// frames, starting in the visible phase after reset.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   digits      : 4 bits per digit, digit i at [4i+3:4i]
//   digit_en    : per-digit enable (0 = dark)
//   dp          : per-digit decimal point (1 = lit)
//   blink_mask  : per-digit blink select (only with SEG_SCAN_BLINK_EN)
//   load        : strobe, captures inputs into the pending buffer
//   an          : anode selects, active-low
//   seg         : {a,b,c,d,e,f,g,dp}, active-low
//   frame_done  : one-cycle pulse after each index wrap
// -----------------------------------------------------------------------------
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int HEX_MODE     = 0
`ifdef SEG_SCAN_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 250
`endif
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   dp,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [7:0]              seg,
   output logic                    frame_done
);

   localparam int CNT_W = $clog2(seg_max(REFRESH_DIV, BLANK_CYCLES) + 1);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   scan_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wrap;

   logic [4*NUM_DIGITS-1:0] pend_dig_q, act_dig_q;
   logic [NUM_DIGITS-1:0]   pend_en_q, act_en_q;
   logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;

   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [7:0]            seg_q, seg_d;
   logic                  fd_q;

   logic [3:0] cur_code;
   logic [7:0] dec_seg;
   logic       hide;

   // The index is a digit number, so {idx,2'b00} is its bit offset.
   assign cur_code = act_dig_q[{idx_q, 2'b00} +: 4];

   seg_decode #(.HEX_MODE(HEX_MODE)) u_decode (
      .code_i (cur_code),
      .seg_o  (dec_seg)
   );

`ifdef SEG_SCAN_BLINK_EN
   localparam int BF_W = $clog2(BLINK_FRAMES + 1);
   localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

   logic [NUM_DIGITS-1:0] pend_bm_q, act_bm_q;
   logic [BF_W-1:0]       fcnt_q;
   logic                  blink_off_q;

   // The blink mask travels through the same double buffer as dp, and the
   // phase only advances on frame boundaries so a digit never blinks mid-frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_bm_q   <= '0;
         act_bm_q    <= '0;
         fcnt_q      <= '0;
         blink_off_q <= 1'b0;
      end else begin
         if (wrap) begin
            act_bm_q <= pend_bm_q;
            if (fcnt_q == BF_LAST) begin
               fcnt_q      <= '0;
               blink_off_q <= ~blink_off_q;
            end else begin
               fcnt_q <= fcnt_q + BF_W'(1);
            end
         end
         if (load) pend_bm_q <= blink_mask;
      end
   end

   assign hide = blink_off_q & act_bm_q[idx_q];
`else
   assign hide = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      wrap    = 1'b0;
      case (state_q)
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = DRIVE;
               cnt_d   = '0;
            end
         end
         DRIVE: begin
            if (cnt_q == DRIVE_LAST) begin
               state_d = BLANK;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  wrap  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = BLANK;
      endcase

      // Outputs are derived from the current state and registered, so the
      // pins show each state one edge after it is entered.
      an_d  = '1;
      seg_d = SEG_BLANK;
      if (state_q == DRIVE && act_en_q[idx_q] && !hide) begin
         an_d  = ~(NUM_DIGITS'(1) << idx_q);
         seg_d = dec_seg & {7'h7F, ~act_dp_q[idx_q]};
      end
   end

   // NOTE: every register here, including the display buffers, is reset so
   // the panel is dark after reset; non-blocking assignments make the wrap
   // copy see the pending contents from before a coincident load.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= BLANK;
         cnt_q      <= '0;
         idx_q      <= '0;
         pend_dig_q <= '0;
         pend_en_q  <= '0;
         pend_dp_q  <= '0;
         act_dig_q  <= '0;
         act_en_q   <= '0;
         act_dp_q   <= '0;
         an_q       <= '1;
         seg_q      <= SEG_BLANK;
         fd_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         fd_q    <= wrap;
         if (wrap) begin
            act_dig_q <= pend_dig_q;
            act_en_q  <= pend_en_q;
            act_dp_q  <= pend_dp_q;
         end
         if (load) begin
            pend_dig_q <= digits;
            pend_en_q  <= digit_en;
            pend_dp_q  <= dp;
         end
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Two instances (HEX_MODE 0 and 1) share all inputs. The reference model
// tracks the edge count since reset and derives the scan position, frame
// number and buffer contents arithmetically from it.
// Optional macro SEG_SCAN_BLINK_EN enables the blink scenario.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int N  = 4;
   localparam int R  = 4;
   localparam int B  = 1;
   localparam int P  = B + R;
   localparam int F  = N * P;
   localparam int BF = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] digits;
   logic [3:0]  digit_en, dp;
   logic        load;
   logic [3:0]  an0, an1;
   logic [7:0]  seg0, seg1;
   logic        fd0, fd1;
`ifdef SEG_SCAN_BLINK_EN
   logic [3:0]  blink_mask;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .HEX_MODE(0)
`ifdef SEG_SCAN_BLINK_EN
      , .BLINK_FRAMES(BF)
`endif
   ) dut0 (
      .clk(clk), .reset(reset), .digits(digits), .digit_en(digit_en), .dp(dp),
`ifdef SEG_SCAN_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .load(load), .an(an0), .seg(seg0), .frame_done(fd0));

   seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .HEX_MODE(1)
`ifdef SEG_SCAN_BLINK_EN
      , .BLINK_FRAMES(BF)
`endif
   ) dut1 (
      .clk(clk), .reset(reset), .digits(digits), .digit_en(digit_en), .dp(dp),
`ifdef SEG_SCAN_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .load(load), .an(an1), .seg(seg1), .frame_done(fd1));

   // ---------------- reference model ----------------
   int          k;          // edges since reset released
   logic [15:0] pend_dig, act_dig;
   logic [3:0]  pend_en, act_en, pend_dp, act_dp;
`ifdef SEG_SCAN_BLINK_EN
   logic [3:0]  pend_bm, act_bm;
`endif
   logic [3:0]  exp_an;
   logic [7:0]  exp_seg0, exp_seg1;
   logic        exp_fd;

   function automatic logic [6:0] ref_decode(input logic [3:0] c, input bit hex);
      case (c)
         4'd0:  return 7'b0000001;
         4'd1:  return 7'b1001111;
         4'd2:  return 7'b0010010;
         4'd3:  return 7'b0000110;
         4'd4:  return 7'b1001100;
         4'd5:  return 7'b0100100;
         4'd6:  return 7'b0100000;
         4'd7:  return 7'b0001111;
         4'd8:  return 7'b0000000;
         4'd9:  return 7'b0000100;
         4'd10: return hex ? 7'b0001000 : 7'b1111111;
         4'd11: return hex ? 7'b1100000 : 7'b1111111;
         4'd12: return hex ? 7'b0110001 : 7'b1111111;
         4'd13: return hex ? 7'b1000010 : 7'b1111111;
         4'd14: return hex ? 7'b0110000 : 7'b1111111;
         default: return hex ? 7'b0111000 : 7'b1111111;
      endcase
   endfunction

   // One rising edge: model follows the inputs present at the edge, then
   // outputs are sampled 1 time unit later by the caller. load auto-clears.
   task automatic tick();
      logic        ld, rst;
      logic [15:0] in_dig;
      logic [3:0]  in_en, in_dp;
      int          s, d, r;
      bit          lit;
`ifdef SEG_SCAN_BLINK_EN
      logic [3:0]  in_bm;
      in_bm = blink_mask;
`endif
      ld = load; rst = reset; in_dig = digits; in_en = digit_en; in_dp = dp;
      @(posedge clk);
      if (rst) begin
         k = 0;
         pend_dig = '0; act_dig = '0; pend_en = '0; act_en = '0; pend_dp = '0; act_dp = '0;
`ifdef SEG_SCAN_BLINK_EN
         pend_bm = '0; act_bm = '0;
`endif
         exp_an = 4'hF; exp_seg0 = 8'hFF; exp_seg1 = 8'hFF; exp_fd = 1'b0;
      end else begin
         s = k;            // position whose state the registered outputs show
         k = k + 1;
         d = (s / P) % N;
         r = s % P;
         lit = (r >= B) && act_en[d];
`ifdef SEG_SCAN_BLINK_EN
         if (act_bm[d] && (((s / F) / BF) % 2 == 1)) lit = 1'b0;
`endif
         exp_an   = lit ? ~(4'b0001 << d) : 4'hF;
         exp_seg0 = lit ? {ref_decode(act_dig[d*4 +: 4], 1'b0), ~act_dp[d]} : 8'hFF;
         exp_seg1 = lit ? {ref_decode(act_dig[d*4 +: 4], 1'b1), ~act_dp[d]} : 8'hFF;
         exp_fd   = (k % F == 0);
         if (exp_fd) begin
            act_dig = pend_dig; act_en = pend_en; act_dp = pend_dp;
`ifdef SEG_SCAN_BLINK_EN
            act_bm = pend_bm;
`endif
         end
         if (ld) begin
            pend_dig = in_dig; pend_en = in_en; pend_dp = in_dp;
`ifdef SEG_SCAN_BLINK_EN
            pend_bm = in_bm;
`endif
         end
      end
      #1;
      load = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({an0, seg0, fd0, an1, seg1, fd1} !== {4'hF, 8'hFF, 1'b0, 4'hF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_init got an=%h seg=%h fd=%b, required an=f seg=ff fd=0", an0, seg0, fd0);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 2 * F; i++) begin
         if (i == 2) begin digits = 16'h4321; digit_en = 4'hF; dp = 4'h0; load = 1'b1; end
         tick();
         checks++;
         if ({an0, seg0, fd0, an1, seg1, fd1} !== {exp_an, exp_seg0, exp_fd, exp_an, exp_seg1, exp_fd}) begin
            errors++;
            $display("FAIL reset_run k=%0d got an=%h/%h seg=%h/%h fd=%b/%b, required an=%h seg=%h/%h fd=%b",
                     k, an0, an1, seg0, seg1, fd0, fd1, exp_an, exp_seg0, exp_seg1, exp_fd);
         end
      end
      // park in the middle of a DRIVE window with digits visible, then reset
      while (k % P != B + 2) tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({an0, seg0, fd0, an1, seg1, fd1} !== {4'hF, 8'hFF, 1'b0, 4'hF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got an=%h seg=%h fd=%b, required an=f seg=ff fd=0", an0, seg0, fd0);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < F + P; i++) begin
         tick();
         checks++;
         if ({an0, seg0, fd0, an1, seg1, fd1} !== {exp_an, exp_seg0, exp_fd, exp_an, exp_seg1, exp_fd}) begin
            errors++;
            $display("FAIL reset_after k=%0d got an=%h/%h seg=%h/%h fd=%b/%b, required an=%h seg=%h/%h fd=%b",
                     k, an0, an1, seg0, seg1, fd0, fd1, exp_an, exp_seg0, exp_seg1, exp_fd);
         end
      end
   endtask

   // Loads 4321 mid-frame, then 9999 during the first visible frame.
   task automatic test_scan_tearing();
      logic [7:0] tbl [4] = '{8'h9F, 8'h25, 8'h0D, 8'h99};
      logic [7:0] want;
      int last_fd = -1;
      int s, d;
      while (k % F != 5) tick();
      digits = 16'h4321; digit_en = 4'hF; dp = 4'h0; load = 1'b1;
      tick();
      while (k % F != 0) tick();
      for (int i = 0; i < 2 * F; i++) begin
         if (i == 7) begin digits = 16'h9999; load = 1'b1; end
         tick();
         checks++;
         if ({an0, seg0, fd0, an1, seg1, fd1} !== {exp_an, exp_seg0, exp_fd, exp_an, exp_seg1, exp_fd}) begin
            errors++;
            $display("FAIL scan_model k=%0d got an=%h/%h seg=%h/%h fd=%b/%b, required an=%h seg=%h/%h fd=%b",
                     k, an0, an1, seg0, seg1, fd0, fd1, exp_an, exp_seg0, exp_seg1, exp_fd);
         end
         s = k - 1;
         if (s % P == B + 1) begin
            d = (s % F) / P;
            want = (i < F) ? tbl[d] : 8'h09;
            checks++;
            if (an0 !== ~(4'b0001 << d) || seg0 !== want) begin
               errors++;
               $display("FAIL scan_digit%0d got an=%h seg=%h, required an=%h seg=%h",
                        d, an0, seg0, ~(4'b0001 << d), want);
            end
         end
         if (fd0 === 1'b1) begin
            if (last_fd >= 0) begin
               checks++;
               if (k - last_fd != F) begin
                  errors++;
                  $display("FAIL frame_period got %0d cycles, required %0d", k - last_fd, F);
               end
            end
            last_fd = k;
         end
      end
   endtask

   // A load on the wrap edge is held for one full frame.
   task automatic test_load_at_wrap();
      int s, d;
      logic [7:0] want;
      while (k % F != F - 1) tick();
      digits = 16'h5555; digit_en = 4'hF; dp = 4'h0; load = 1'b1;
      tick();
      for (int i = 0; i < 2 * F; i++) begin
         tick();
         s = k - 1;
         if (s % P == B + 1) begin
            d = (s % F) / P;
            want = (i < F) ? 8'h09 : 8'h49;
            checks++;
            if (seg0 !== want || seg0 !== exp_seg0) begin
               errors++;
               $display("FAIL wrap_load digit%0d got seg=%h, required %h (model %h)", d, seg0, want, exp_seg0);
            end
         end
      end
   endtask

   task automatic test_blank_dp();
      logic [3:0] an_t [4]  = '{4'b1110, 4'b1101, 4'hF, 4'b0111};
      logic [7:0] seg_t [4] = '{8'h9E, 8'h25, 8'hFF, 8'h99};
      int s, d;
      while (k % F != 3) tick();
      digits = 16'h4321; digit_en = 4'b1011; dp = 4'b0001; load = 1'b1;
      tick();
      while (k % F != 0) tick();
      for (int i = 0; i < F; i++) begin
         tick();
         checks++;
         if ({an0, seg0, fd0, an1, seg1, fd1} !== {exp_an, exp_seg0, exp_fd, exp_an, exp_seg1, exp_fd}) begin
            errors++;
            $display("FAIL blank_model k=%0d got an=%h seg=%h fd=%b, required an=%h seg=%h fd=%b",
                     k, an0, seg0, fd0, exp_an, exp_seg0, exp_fd);
         end
         s = k - 1;
         if (s % P == B + 1) begin
            d = (s % F) / P;
            checks++;
            if (an0 !== an_t[d] || seg0 !== seg_t[d]) begin
               errors++;
               $display("FAIL blank_dp digit%0d got an=%h seg=%h, required an=%h seg=%h",
                        d, an0, seg0, an_t[d], seg_t[d]);
            end
         end
      end
   endtask

   task automatic test_hex();
      logic [7:0] hex_t [4] = '{8'h63, 8'h85, 8'h61, 8'h71};
      int s, d;
      while (k % F != 3) tick();
      digits = 16'hFEDC; digit_en = 4'hF; dp = 4'h0; load = 1'b1;
      tick();
      while (k % F != 0) tick();
      for (int i = 0; i < F; i++) begin
         tick();
         s = k - 1;
         if (s % P == B + 1) begin
            d = (s % F) / P;
            checks++;
            if (seg0 !== 8'hFF || seg1 !== hex_t[d] || an1 !== ~(4'b0001 << d)) begin
               errors++;
               $display("FAIL hex digit%0d got seg0=%h seg1=%h an1=%h, required seg0=ff seg1=%h an1=%h",
                        d, seg0, seg1, an1, hex_t[d], ~(4'b0001 << d));
            end
         end
      end
   endtask

`ifdef SEG_SCAN_BLINK_EN
   task automatic test_blink();
      int s, d, vis0, vis1;
      vis0 = 0; vis1 = 0;
      while (k % F != 3) tick();
      digits = 16'h4321; digit_en = 4'hF; dp = 4'h0; blink_mask = 4'b0001; load = 1'b1;
      tick();
      while (k % F != 0) tick();
      for (int i = 0; i < 9 * F; i++) begin
         tick();
         checks++;
         if ({an0, seg0, fd0, an1, seg1, fd1} !== {exp_an, exp_seg0, exp_fd, exp_an, exp_seg1, exp_fd}) begin
            errors++;
            $display("FAIL blink_model k=%0d got an=%h seg=%h, required an=%h seg=%h",
                     k, an0, seg0, exp_an, exp_seg0);
         end
         s = k - 1;
         if (i >= F && s % P == B + 1) begin
            d = (s % F) / P;
            if (d == 0 && an0 === 4'b1110) vis0++;
            if (d == 1 && an0 === 4'b1101) vis1++;
         end
      end
      checks++;
      if (vis0 != 4 || vis1 != 8) begin
         errors++;
         $display("FAIL blink_count got digit0 visible %0d digit1 visible %0d frames, required 4 and 8", vis0, vis1);
      end
      blink_mask = 4'h0;
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 7) == 0) begin
            digits   = 16'($urandom);
            digit_en = 4'($urandom);
            dp       = 4'($urandom);
`ifdef SEG_SCAN_BLINK_EN
            blink_mask = 4'($urandom);
`endif
            load = 1'b1;
         end
         tick();
         checks++;
         if ({an0, seg0, fd0, an1, seg1, fd1} !== {exp_an, exp_seg0, exp_fd, exp_an, exp_seg1, exp_fd}) begin
            errors++;
            $display("FAIL random k=%0d got an=%h/%h seg=%h/%h fd=%b/%b, required an=%h seg=%h/%h fd=%b",
                     k, an0, an1, seg0, seg1, fd0, fd1, exp_an, exp_seg0, exp_seg1, exp_fd);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; digits = '0; digit_en = '0; dp = '0; load = 1'b0; k = 0;
`ifdef SEG_SCAN_BLINK_EN
      blink_mask = '0;
`endif
      test_reset();
      test_scan_tearing();
      test_load_at_wrap();
      test_blank_dp();
      test_hex();
`ifdef SEG_SCAN_BLINK_EN
      test_blink();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before tests completed");
      $fatal(1, "watchdog");
   end

endmodule
